// File: rtl/pmem_responder_pkg.sv
// rtl/pmem_responder_pkg.sv - shared types and constants for the pmem responder
package pmem_responder_pkg;

    localparam int PMEM_LINE_BITS   = 12;
    localparam int LC3B_LINE_OFFSET = 4;

    typedef logic [15:0]               lc3b_word;
    typedef logic [127:0]              lc3b_data;
    typedef logic [PMEM_LINE_BITS-1:0] lc3b_line_idx;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } pmem_state_t;

endpackage

// File: rtl/pmem_responder_array.sv
// rtl/pmem_responder_array.sv - single-port line-wide RAM with registered read data
module pmem_array
    import pmem_responder_pkg::*;
#(
    parameter int ADDR_BITS = PMEM_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_we,
    input  lc3b_data             i_wdata,
    input  logic                 i_re,
    output lc3b_data             o_rdata
);

    lc3b_data r_mem [2**ADDR_BITS];
    lc3b_data r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read data only moves on an explicit read, so it doubles as the held read line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line-wide memory end of the cache pmem interface
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY   = 10,
    parameter int LINE_BITS = PMEM_LINE_BITS
) (
    input  logic     clk,
    input  logic     rst_n,
    input  lc3b_word pmem_address,
    input  logic     pmem_read,
    input  logic     pmem_write,
    input  lc3b_data pmem_wdata,
    output lc3b_data pmem_rdata,
    output logic     pmem_resp,
    output logic     busy,
    output logic     proto_err
);

    localparam int               CW     = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]    LAT_C  = CW'(LATENCY);
    localparam logic [CW-1:0]    LAT_M1 = CW'(LATENCY - 1);

    pmem_state_t          r_state;
    logic [CW-1:0]        r_count;
    logic [LINE_BITS-1:0] r_idx;
    logic                 r_is_write;
    lc3b_data             r_wdata;
    logic                 r_resp;
    logic                 r_busy;
    logic                 r_proto_err;

    logic [LINE_BITS-1:0] w_req_idx;
    logic                 w_req;
    logic                 w_req_dropped;
    logic                 w_wait_done;
    logic                 w_ram_re;
    logic                 w_ram_we;
    logic [LINE_BITS-1:0] w_ram_addr;
    logic                 w_unused_addr;

    assign w_req_idx     = pmem_address[LC3B_LINE_OFFSET +: LINE_BITS];
    assign w_unused_addr = ^pmem_address[LC3B_LINE_OFFSET-1:0];
    assign w_req         = pmem_read | pmem_write;
    assign w_req_dropped = r_is_write ? !pmem_write : !pmem_read;
    assign w_wait_done   = (r_state == WAIT) && !w_req_dropped && (r_count == LAT_M1);

    // Read is launched on the edge entering RESP so the line is on pmem_rdata during RESP.
    assign w_ram_re   = ((r_state == IDLE) && (LATENCY == 1) && pmem_read && !pmem_write)
                      || (w_wait_done && !r_is_write);
    assign w_ram_we   = (r_state == RESP) && r_is_write;
    assign w_ram_addr = (r_state == IDLE) ? w_req_idx : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_is_write  <= 1'b0;
            r_wdata     <= '0;
            r_resp      <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_req_idx;
                        r_is_write <= pmem_write;
                        r_wdata    <= pmem_wdata;
                        r_count    <= CW'(1);
                        r_busy     <= 1'b1;
                        if (pmem_read && pmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_req_dropped) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        r_busy      <= 1'b0;
                        r_proto_err <= 1'b1;
                    end else begin
                        if (r_count < LAT_C) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (r_count == LAT_M1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    pmem_array #(
        .ADDR_BITS (LINE_BITS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (r_wdata),
        .i_re    (w_ram_re),
        .o_rdata (pmem_rdata)
    );

    assign pmem_resp = r_resp;
    assign busy      = r_busy;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed and randomized bench for pmem_responder
module tb_pmem_responder;

    localparam int LATENCY = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [127:0] pmem_wdata = '0;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;
    logic         proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] model_mem [int];
    logic [127:0] exp_rdata = '0;
    logic         exp_perr  = 1'b0;

    pmem_responder #(.LATENCY(LATENCY), .LINE_BITS(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One requester transaction. drop_at >= 0 releases the request after that many edges.
    task automatic txn(input bit wr, input bit both, input logic [15:0] addr,
                       input logic [127:0] wd, input int drop_at, input string tag);
        int idx;
        int resp_k;
        int n_resp;
        idx    = int'(addr[15:4]);
        resp_k = -1;
        n_resp = 0;
        @(negedge clk);
        pmem_address = addr;
        pmem_wdata   = wd;
        pmem_write   = wr;
        pmem_read    = !wr || both;
        @(posedge clk);
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, " busy_after_accept"}, 128'(busy), 128'(1'b1));
            if (k == drop_at + 1 && drop_at >= 0) chk({tag, " busy_after_drop"}, 128'(busy), 128'(1'b0));
            if (pmem_resp) begin
                n_resp++;
                if (resp_k < 0) resp_k = k;
                if (!wr) chk({tag, " rdata"}, pmem_rdata, model_mem[idx]);
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (k == drop_at) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            pmem_address = 16'($urandom());
            pmem_wdata   = {4{$urandom()}};
        end
        if (drop_at < 0) begin
            chk({tag, " resp_count"}, 128'(n_resp), 128'(1));
            chk({tag, " resp_latency"}, 128'(resp_k + 1), 128'(LATENCY));
            if (wr) model_mem[idx] = wd;
            else    exp_rdata = model_mem[idx];
            if (both) exp_perr = 1'b1;
        end else begin
            chk({tag, " no_resp_on_abort"}, 128'(n_resp), 128'(0));
            exp_perr = 1'b1;
        end
        chk({tag, " rdata_hold"}, pmem_rdata, exp_rdata);
        chk({tag, " proto_err"}, 128'(proto_err), 128'(exp_perr));
    endtask

    logic [11:0]  line_tab [8];
    logic [127:0] a5_line;
    logic [127:0] pat_line;
    int           gap;

    initial begin
        line_tab = '{12'h000, 12'h001, 12'h0FF, 12'h100, 12'h800, 12'hFFF, 12'h3A5, 12'h5C3};
        a5_line  = {16{8'hA5}};
        pat_line = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

        repeat (3) @(negedge clk);
        chk("reset resp", 128'(pmem_resp), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset rdata", pmem_rdata, 128'(0));
        chk("reset proto_err", 128'(proto_err), 128'(0));
        rst_n = 1'b1;

        txn(1'b1, 1'b0, 16'h0120, a5_line, -1, "t1_preload");
        txn(1'b0, 1'b0, 16'h0123, '0, -1, "t1_read");

        txn(1'b1, 1'b0, 16'h4560, pat_line, -1, "t2_write");
        txn(1'b0, 1'b0, 16'h456F, '0, -1, "t2_read");

        txn(1'b0, 1'b0, 16'h0125, '0, 4, "t3_abort_read");
        txn(1'b0, 1'b0, 16'h0120, '0, -1, "t3_line_intact");

        txn(1'b1, 1'b1, 16'h7770, 128'd1, -1, "t4_both");
        txn(1'b0, 1'b0, 16'h7771, '0, -1, "t4_readback");

        // t5: request held across two transactions, address switched during the first RESP.
        @(negedge clk);
        pmem_address = 16'h0120;
        pmem_read    = 1'b1;
        @(posedge clk);
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                chk("t5 first rdata", pmem_rdata, model_mem[12'h012]);
                pmem_address = 16'h4568;
                break;
            end
        end
        gap = -1;
        for (int j = 1; j < LATENCY + 6; j++) begin
            @(negedge clk);
            if (pmem_resp) begin
                gap = j;
                chk("t5 second rdata", pmem_rdata, model_mem[12'h456]);
                pmem_read = 1'b0;
                break;
            end
        end
        chk("t5 resp spacing", 128'(gap), 128'(LATENCY + 1));
        exp_rdata = model_mem[12'h456];
        repeat (2) @(negedge clk);

        // t6: reset lands mid-write.
        @(negedge clk);
        pmem_address = 16'h0120;
        pmem_wdata   = '1;
        pmem_write   = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 resp", 128'(pmem_resp), 128'(0));
        chk("t6 busy", 128'(busy), 128'(0));
        chk("t6 rdata", pmem_rdata, 128'(0));
        chk("t6 proto_err", 128'(proto_err), 128'(0));
        exp_rdata = '0;
        exp_perr  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 idle after release", 128'(busy), 128'(0));
        txn(1'b0, 1'b0, 16'h0120, '0, -1, "t6_line_intact");

        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 1'b0, {line_tab[i], 4'(i)}, {4{$urandom()}}, -1, "rnd_init");
        end
        for (int i = 0; i < 24; i++) begin
            bit wr;
            bit both;
            int drop;
            wr   = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 5) == 0);
            drop = (!both && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, LATENCY - 2)) : -1;
            txn(wr, both, {line_tab[$urandom_range(0, 7)], 4'($urandom())}, {4{$urandom()}}, drop, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
